prach_hb4_pack: RTL and testbench
=================================

# prach_hb4_pack

Polyphase pairing stage directly upstream of the HB4 half-band decimator in the PRACH long-format chain. Takes the full-rate TDM stream (one 16-bit sample per channel slot, 128-slot frame, channels 0..47 used). Holds each channel's even-frame sample in a 48-deep buffer and, on the following odd frame, emits the pair (dp1 = even sample, dp2 = odd sample) tagged with its channel. Slots that must not advance the decimator's delay lines are tagged with an idle channel code.

## Interface
Parameters
- `NumChannel`, 128: TDM slots per frame.
- `NumChannelUsed`, 48: active channels, slots 0..NumChannelUsed-1.

Ports
- `clk` in 1: the block's single clock.
- `rst` in 1: reset; synchronous, active-high.
- `din` in 16: signed sample for slot `din_chn`.
- `din_chn` in 8: slot index, counts 0..127 and wraps, one per cycle.
- `sync_in` in 1: frame-start pulse; coincides with `din_chn == 0`.
- `dout_dp1` out 16: even-phase sample of the pair.
- `dout_dp2` out 16: odd-phase sample of the pair.
- `dout_chn` out 8: channel of the pair, or `ChnIdle` (8'hFF).
- `sync_out` out 1: `sync_in` delayed to match the data latency.
- `err` out 1: sticky framing error flag.

## Operation
- Phase bit `ph`, reset 0:
  - Toggles on each cycle with `din_chn == 127`.
  - A `sync_in` cycle forces `ph = 0` for the frame starting that cycle. This overrides any toggle.
- Even frame (`ph == 0`), slot c < 48: write `din` to buffer address c. The output is idle.
- Odd frame (`ph == 1`), slot c < 48:
  - Read buffer address c.
  - Present `dout_dp1` = buffer[c], `dout_dp2` = `din` (held aligned), `dout_chn` = c.
- Slots c ≥ 48 in either frame: `dout_chn` = 8'hFF. `dout_dp1`/`dout_dp2` hold their previous values.
  - 8'hFF is used because 255 mod 128 = 127 ≥ 48, so the decimator ignores it.
- Write and read of the same address always fall in different frames, so no read/write collision handling is needed.
- Framing checks (each sets sticky `err`; only `rst` clears it):
  - `sync_in` with `din_chn != 0`.
  - `din_chn` not equal to (previous `din_chn` + 1) mod 128.
- On a discontinuity, `ph` is forced to 0 from the offending sample onward. The partial pair is discarded and the next pair is emitted only after a full even frame has been captured.
- Until the first `sync_in` or first wrap after reset, the block treats the frame as even and emits only idle tags.
- Arithmetic: none. Samples pass bit-exact with no rounding, saturation or sign change.

## Timing
- Latency is 2 cycles from `din`/`din_chn` to `dout_*`: buffer read 1 cycle plus output register 1 cycle.
- `dout_dp2` takes the odd-frame `din` through a matching 2-stage register.
- `sync_out` equals `sync_in` delayed exactly 2 cycles, identical to the data path.
- Reset values:
  - `dout_dp1`, `dout_dp2` = 0.
  - `dout_chn` = 8'hFF.
  - `sync_out` = 0, `err` = 0, `ph` = 0.
  - The previous-chn register is preset to 127 so that a first sample at slot 0 passes the check.
- Buffer contents are not reset; they are not observable until overwritten.
- `rst` asserted mid-frame:
  - Outputs return to reset values on the next edge.
  - Pairing resumes only after a complete even frame.
  - The 2 pipeline cycles in flight are dropped, with `dout_chn` forced to 8'hFF.
- Throughput: one input per cycle, no backpressure.

## Structure
- Shared package `prach_pkg` holds: `NumChannel`, `NumChannelUsed`, `ChnIdle = 8'hFF`, and the 16-bit sample typedef `prach_sample_t`, used by both this block and HB4.
- Buffer: 48×16 simple dual-port memory with `ramstyle = "mlab"` and registered read.
- Sub-module: reuse existing `delay` (WIDTH 1, DELAY 2) for `sync_out`. Its `rst_n` is tied to 1, and its output is gated to 0 while `rst` pipeline flush is active.

## Test plan
- Steady state: `din` = {frame, chn} pattern, sync every 256 cycles.
  - Odd frame slot 5 output, 2 cycles later: dp1 = even value at slot 5, dp2 = odd value, `dout_chn` = 5.
  - Even frames: all tags 8'hFF.
  - `err` stays 0.
- Unused slots: slots 48..127 never produce `dout_chn` < 255, and dp1/dp2 hold across them.
- Misplaced sync: `sync_in` at `din_chn` = 10.
  - `err` = 1 next cycle and stays 1.
  - The next frame is treated as even (idle tags), and pairs resume the frame after.
- Slot skip: `din_chn` jumps 20→22 in an odd frame.
  - `err` = 1.
  - Slots ≥ 22 of that frame are tagged 8'hFF.
  - Valid pairs reappear only after the next full even frame.
- Reset mid-odd-frame at slot 30:
  - All outputs at reset values the following cycle, including `dout_chn` = 8'hFF.
  - No pair is emitted until an even plus an odd frame have elapsed.
- Chained with `prach_hb4`: feed an impulse into channel 0 at 0x4000.
  - The HB4 output for channel 0 shows the coefficient sequence scaled by 0x4000, with total latency = 2 + 7 cycles.
  - `sync_out` aligns with the first pair of the frame.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared PRACH constants and sample type, used by the HB4 pairing stage and the HB4 decimator.
package prach_pkg;
  localparam int NumChannel = 128;
  localparam int NumChannelUsed = 48;
  localparam logic [7:0] ChnIdle = 8'hFF;

  typedef logic signed [15:0] prach_sample_t;
endpackage

// File: rtl/delay.sv
// Generic fixed-latency shift register.
module delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DELAY-1];

endmodule

// File: rtl/prach_hb4_pack.sv
// Pairs each channel's even-frame sample with its odd-frame sample for the HB4 decimator.
// Slots outside a valid odd frame are tagged ChnIdle so the decimator does not advance.
module prach_hb4_pack #(
  parameter int NumChannel     = prach_pkg::NumChannel,
  parameter int NumChannelUsed = prach_pkg::NumChannelUsed
) (
  input  logic                    clk,
  input  logic                    rst,
  input  prach_pkg::prach_sample_t din,
  input  logic [7:0]              din_chn,
  input  logic                    sync_in,
  output prach_pkg::prach_sample_t dout_dp1,
  output prach_pkg::prach_sample_t dout_dp2,
  output logic [7:0]              dout_chn,
  output logic                    sync_out,
  output logic                    err
);
  import prach_pkg::*;

  localparam int AddrW = $clog2(NumChannelUsed);
  localparam logic [7:0] LastSlot = 8'(NumChannel - 1);
  localparam logic [7:0] UsedLim  = 8'(NumChannelUsed);

  logic ph;
  logic armed;          // current even frame began cleanly at slot 0
  logic [7:0] prev_chn;
  logic [1:0] flush;

  logic [7:0]    tag1;
  prach_sample_t din1;
  prach_sample_t rd_data;
  logic          sync_dly;

  (* ramstyle = "mlab" *) prach_sample_t mem [NumChannelUsed];

  logic [7:0]       chn_exp;
  logic             bad;
  logic             ph_cur;
  logic             armed_cur;
  logic             in_used;
  logic             wr_en;
  logic             rd_en;
  logic [AddrW-1:0] addr;

  always_comb begin
    chn_exp   = (prev_chn == LastSlot) ? 8'd0 : prev_chn + 8'd1;
    bad       = (din_chn != chn_exp) || (sync_in && (din_chn != 8'd0));
    ph_cur    = ph && !sync_in && !bad;
    armed_cur = armed;
    if (bad) armed_cur = 1'b0;
    else if ((din_chn == 8'd0) && !ph_cur) armed_cur = 1'b1;
    in_used   = din_chn < UsedLim;
    addr      = din_chn[AddrW-1:0];
    wr_en     = !rst && in_used && !ph_cur;
    rd_en     = in_used && ph_cur;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= din;
    if (rd_en) rd_data <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= 1'b0;
      armed    <= 1'b0;
      prev_chn <= LastSlot;
      err      <= 1'b0;
      flush    <= 2'd2;
      tag1     <= ChnIdle;
      din1     <= '0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_chn <= ChnIdle;
    end else begin
      prev_chn <= din_chn;
      err      <= err | bad;
      armed    <= armed_cur;
      // only a complete even frame may hand over to an odd frame
      ph       <= (din_chn == LastSlot) ? (!ph_cur && armed_cur) : ph_cur;
      if (flush != 2'd0) flush <= flush - 2'd1;
      tag1     <= rd_en ? din_chn : ChnIdle;
      if (rd_en) din1 <= din;
      dout_chn <= tag1;
      if (tag1 != ChnIdle) begin
        dout_dp1 <= rd_data;
        dout_dp2 <= din1;
      end
    end
  end

  delay #(.WIDTH(1), .DELAY(2)) u_sync_dly (
    .clk   (clk),
    .rst_n (1'b1),
    .din   (sync_in),
    .dout  (sync_dly)
  );

  // the delay line is not reset, so mask what it held across a reset
  assign sync_out = sync_dly && (flush == 2'd0);

endmodule

// File: tb/tb_prach_hb4_pack.sv
// Self-checking bench for prach_hb4_pack: table vectors on a known pattern, then random
// streams with framing faults, all compared every cycle against a frame-level model.
module tb_prach_hb4_pack;
  import prach_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic [15:0] dout_dp1, dout_dp2;
  logic [7:0]  dout_chn;
  logic        sync_out, err;

  prach_hb4_pack dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: seq counts samples of a clean run anchored at a slot-0 frame start (-1 = no run);
  // odd-numbered frames of such a run are the pairing frames.
  int          seq = -1;
  int          m_prev = 127;
  bit          m_err = 1'b0;
  logic [15:0] ebuf [48];
  logic [7:0]  s1_chn = 8'hFF;
  logic [15:0] s1_dp1 = '0, s1_dp2 = '0;
  bit          s1_sync = 1'b0;
  logic [15:0] e_dp1 = '0, e_dp2 = '0;
  logic [7:0]  e_chn = 8'hFF;
  bit          e_sync = 1'b0;

  logic [7:0] nxt = '0;
  int         frm = 0;
  int         sent = 0;

  typedef struct {
    int          frame;
    int          slot;
    logic [7:0]  chn;
    logic [15:0] dp1;
    logic [15:0] dp2;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit odd_now();
    return (seq >= 0) && (((seq / 128) % 2) == 1);
  endfunction

  task automatic cyc(input logic [15:0] d, input logic [7:0] c, input bit s, input bit r);
    bit bad;
    din = d; din_chn = c; sync_in = s; rst = r;
    bad = (int'(c) != (m_prev + 1) % 128) || (s && c != 8'd0);
    if (r) begin
      seq = -1; m_prev = 127; m_err = 1'b0;
      s1_chn = 8'hFF; s1_sync = 1'b0;
      e_dp1 = '0; e_dp2 = '0; e_chn = 8'hFF; e_sync = 1'b0;
    end else begin
      e_chn = s1_chn; e_sync = s1_sync;
      if (s1_chn != 8'hFF) begin e_dp1 = s1_dp1; e_dp2 = s1_dp2; end
      m_err = m_err | bad;
      m_prev = int'(c);
      if (bad) seq = -1;
      else if (s) seq = 0;
      else if (seq >= 0) seq++;
      else if (c == 8'd0) seq = 0;
      s1_sync = s;
      s1_chn = 8'hFF;
      if (c < 8'd48) begin
        if (odd_now()) begin
          s1_chn = c; s1_dp1 = ebuf[c]; s1_dp2 = d;
        end else begin
          ebuf[c] = d;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("dout_chn", 32'(dout_chn), 32'(e_chn));
    chk("dout_dp1", 32'(dout_dp1), 32'(e_dp1));
    chk("dout_dp2", 32'(dout_dp2), 32'(e_dp2));
    chk("sync_out", 32'(sync_out), 32'(e_sync));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // next slot of the TDM stream; sync at slot 0 of every other frame
  task automatic send(input logic [15:0] d);
    cyc(d, nxt, (nxt == 8'd0) && (frm % 2 == 0), 1'b0);
    sent++;
    if (nxt == 8'd127) begin nxt = 8'd0; frm++; end
    else nxt = nxt + 8'd1;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send(16'($urandom));
  endtask

  task automatic clean_reset();
    for (int i = 0; i < 3; i++) cyc(16'($urandom), 8'(125 + i), 1'b0, 1'b1);
    nxt = 8'd0; frm = 0; sent = 0;
  endtask

  task automatic run_to_odd_slot(input logic [7:0] slot, input string name);
    int n = 0;
    while (!(nxt == slot && odd_now()) && n < 1024) begin
      send(16'($urandom));
      n++;
    end
    if (n >= 1024) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no odd frame reached slot %0d within 1024 cycles", name, slot);
    end
  endtask

  initial begin
    vecs[0] = '{0,   5, 8'hFF, 16'h0000, 16'h0000};
    vecs[1] = '{1,   0, 8'd0,  16'h0000, 16'h0100};
    vecs[2] = '{1,   5, 8'd5,  16'h0005, 16'h0105};
    vecs[3] = '{1,  47, 8'd47, 16'h002F, 16'h012F};
    vecs[4] = '{1,  48, 8'hFF, 16'h002F, 16'h012F};
    vecs[5] = '{1, 127, 8'hFF, 16'h002F, 16'h012F};
    vecs[6] = '{2,   5, 8'hFF, 16'h002F, 16'h012F};
    vecs[7] = '{3,   0, 8'd0,  16'h0200, 16'h0300};
    vecs[8] = '{3,  30, 8'd30, 16'h021E, 16'h031E};
    vecs[9] = '{3, 100, 8'hFF, 16'h022F, 16'h032F};

    clean_reset();
    chk("reset_chn", 32'(dout_chn), 32'h0FF);
    chk("reset_dp1", 32'(dout_dp1), 32'h0);
    chk("reset_dp2", 32'(dout_dp2), 32'h0);
    chk("reset_sync_out", 32'(sync_out), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // pattern din = {frame, slot}; outputs lag the sample by two cycles
    for (int k = 0; k < 10; k++) begin
      while (sent < vecs[k].frame * 128 + vecs[k].slot + 2) send({8'(frm), nxt});
      chk($sformatf("vec%0d_chn", k), 32'(dout_chn), 32'(vecs[k].chn));
      chk($sformatf("vec%0d_dp1", k), 32'(dout_dp1), 32'(vecs[k].dp1));
      chk($sformatf("vec%0d_dp2", k), 32'(dout_dp2), 32'(vecs[k].dp2));
    end
    while (sent < 512) send({8'(frm), nxt});

    send_rand(4 * 128);

    // misplaced sync at slot 10
    send_rand(10);
    cyc(16'($urandom), 8'd10, 1'b1, 1'b0);
    nxt = 8'd11;
    chk("err_after_bad_sync", 32'(err), 32'h1);
    send_rand(3 * 128);
    chk("err_sticky", 32'(err), 32'h1);

    // slot skip 20 -> 22 inside an odd frame
    clean_reset();
    run_to_odd_slot(8'd21, "wait_skip");
    nxt = 8'd22;
    send(16'($urandom));
    chk("err_after_skip", 32'(err), 32'h1);
    send_rand(3 * 128);

    // reset in the middle of an odd frame at slot 30
    run_to_odd_slot(8'd30, "wait_rst");
    cyc(16'($urandom), 8'd30, 1'b0, 1'b1);
    nxt = 8'd31;
    chk("midrst_chn", 32'(dout_chn), 32'h0FF);
    chk("midrst_dp1", 32'(dout_dp1), 32'h0);
    chk("midrst_dp2", 32'(dout_dp2), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    send_rand(3 * 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
